// File: rtl/sspp_job_driver.sv
// rtl/sspp_job_driver.sv - Start/Busy job initiator with result stream and watchdog abort.
// Optional job counters (jobs_done/jobs_timeout) when SSPP_DRV_PERF_CNT_EN is defined.
module sspp_job_driver #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_timeout,
  output logic [DATA_W-1:0] proc_InA,
  output logic [DATA_W-1:0] proc_InB,
  output logic              proc_Start,
  input  logic              proc_Busy,
  input  logic [DATA_W-1:0] proc_Out
`ifdef SSPP_DRV_PERF_CNT_EN
  ,
  output logic [15:0]       jobs_done,
  output logic [15:0]       jobs_timeout
`endif
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    RESULT
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [WD_W-1:0]  wdCnt;
  logic [WD_W-1:0]  wdInc;
  logic             wdHit;
  logic             accept;
  logic             finishOk;
  logic             finishTo;
  logic             resTaken;

  assign op_ready = (state == IDLE);

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    finishOk  = 1'b0;
    finishTo  = 1'b0;
    resTaken  = 1'b0;
    wdInc     = wdCnt + WD_W'(1);
    // The watchdog wins over a Busy fall that lands on the same cycle.
    wdHit     = (wdInc == WD_W'(TIMEOUT_CYCLES));
    unique case (state)
      IDLE: begin
        if (op_valid) begin
          accept    = 1'b1;
          stateNext = LAUNCH;
        end
      end
      LAUNCH: stateNext = WAIT_BUSY;
      WAIT_BUSY: begin
        if (wdHit) begin
          finishTo  = 1'b1;
          stateNext = RESULT;
        end else if (proc_Busy) begin
          stateNext = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (wdHit) begin
          finishTo  = 1'b1;
          stateNext = RESULT;
        end else if (!proc_Busy) begin
          finishOk  = 1'b1;
          stateNext = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          resTaken  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wdCnt       <= '0;
      proc_Start  <= 1'b0;
      proc_InA    <= '0;
      proc_InB    <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_timeout <= 1'b0;
    end else begin
      state      <= stateNext;
      proc_Start <= accept;
      if (accept) begin
        proc_InA <= op_a;
        proc_InB <= op_b;
      end
      if (state == LAUNCH) begin
        wdCnt <= '0;
      end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
        wdCnt <= wdInc;
      end
      if (finishOk) begin
        res_data    <= proc_Out;
        res_timeout <= 1'b0;
        res_valid   <= 1'b1;
      end else if (finishTo) begin
        res_data    <= '0;
        res_timeout <= 1'b1;
        res_valid   <= 1'b1;
      end else if (resTaken) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef SSPP_DRV_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jobs_done    <= '0;
      jobs_timeout <= '0;
    end else if (resTaken) begin
      if (jobs_done != 16'hFFFF) begin
        jobs_done <= jobs_done + 16'd1;
      end
      if (res_timeout && jobs_timeout != 16'hFFFF) begin
        jobs_timeout <= jobs_timeout + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sspp_job_driver.sv
// tb/tb_sspp_job_driver.sv - randomized bench for sspp_job_driver with gcd processor model.
// Optional counter checks follow SSPP_DRV_PERF_CNT_EN.
module tb_sspp_job_driver;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          opValid;
  logic          opReady;
  logic [DW-1:0] opA;
  logic [DW-1:0] opB;
  logic          resValid;
  logic          resReady;
  logic [DW-1:0] resData;
  logic          resTimeout;
  logic [DW-1:0] procInA;
  logic [DW-1:0] procInB;
  logic          procStart;
  logic          procBusy;
  logic [DW-1:0] procOut;
`ifdef SSPP_DRV_PERF_CNT_EN
  logic [15:0]   jobsDone;
  logic [15:0]   jobsTimeout;
`endif

  int checks = 0;
  int errors = 0;
  int mode = 0;        // 0 gcd processor, 1 Busy tied low, 2 Busy tied high
  int curB = 5;
  int busyLeft = 0;
  bit startSeen = 1'b0;

  sspp_job_driver #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .op_valid(opValid), .op_ready(opReady), .op_a(opA), .op_b(opB),
    .res_valid(resValid), .res_ready(resReady), .res_data(resData), .res_timeout(resTimeout),
    .proc_InA(procInA), .proc_InB(procInB), .proc_Start(procStart),
    .proc_Busy(procBusy), .proc_Out(procOut)
`ifdef SSPP_DRV_PERF_CNT_EN
    , .jobs_done(jobsDone), .jobs_timeout(jobsTimeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Processor: Busy rises the cycle after Start, stays curB cycles, Out = gcd(InA, InB).
  initial begin
    procBusy = 1'b0;
    procOut  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        busyLeft  = 0;
        startSeen = 1'b0;
      end else begin
        if (startSeen) begin
          busyLeft  = curB;
          procOut   = gcd(procInA, procInB);
          startSeen = 1'b0;
        end else if (busyLeft > 0) begin
          busyLeft--;
        end
        if (procStart) startSeen = 1'b1;
      end
      procBusy = (mode == 2) || (mode == 0 && busyLeft > 0);
    end
  end

  task automatic waitIdle;
    int k;
    k = 0;
    while ((busyLeft > 0 || startSeen) && k < 60) begin
      tick;
      k++;
    end
  endtask

  // Reference: job spends min(B+1, TO) cycles waiting, timeout when that reaches TO.
  task automatic runJob(input logic [7:0] a, input logic [7:0] b, input int bLen,
                        input int hold, input string tag);
    int k;
    int starts;
    int expLat;
    bit expTo;
    bit stable;
    bit bad;
    logic [7:0] expData;
    curB    = bLen;
    expTo   = (mode != 0) || (bLen + 1 >= TO);
    expLat  = (expTo ? TO : bLen + 1) + 1;
    expData = expTo ? 8'h00 : gcd(a, b);
    resReady = 1'b0;
    chk({tag, " op_ready before"}, opReady, 1);
    opValid = 1'b1;
    opA = a;
    opB = b;
    tick;
    opValid = 1'b0;
    opA = $urandom_range(0, 255);
    opB = $urandom_range(0, 255);
    chk({tag, " start"}, procStart, 1);
    chk({tag, " InA"}, procInA, a);
    chk({tag, " InB"}, procInB, b);
    k = 0;
    starts = 0;
    stable = 1'b1;
    while (!resValid && k < 100) begin
      tick;
      k++;
      starts += int'(procStart);
      if (procInA !== a || procInB !== b || opReady !== 1'b0) stable = 1'b0;
    end
    chk({tag, " latency"}, k, expLat);
    chk({tag, " timeout"}, resTimeout, expTo);
    chk({tag, " data"}, resData, expData);
    chk({tag, " extra starts"}, starts, 0);
    chk({tag, " busy phase stable"}, stable, 1);
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick;
      if (resValid !== 1'b1 || resData !== expData || resTimeout !== expTo ||
          opReady !== 1'b0 || procStart !== 1'b0 || procInA !== a) bad = 1'b1;
    end
    if (hold > 0) chk({tag, " backpressure hold"}, bad, 0);
    resReady = 1'b1;
    tick;
    resReady = 1'b0;
    chk({tag, " res_valid cleared"}, resValid, 0);
    chk({tag, " op_ready after"}, opReady, 1);
    waitIdle();
  endtask

  task automatic doReset;
    #2;
    reset = 1'b0;
    tick;
    tick;
    #2;
    reset = 1'b1;
    tick;
  endtask

  initial begin
    logic [7:0] ba [3];
    logic [7:0] bb [3];
    logic [7:0] got [$];
    logic [7:0] d;
    bit acc;
    bit tk;
    int idx;
    int k;

    reset = 1'b0;
    opValid = 1'b0;
    opA = '0;
    opB = '0;
    resReady = 1'b0;
    tick;
    tick;
    chk("reset res_valid", resValid, 0);
    chk("reset start", procStart, 0);
    chk("reset InA", procInA, 0);
    chk("reset InB", procInB, 0);
    chk("reset res_data", resData, 0);
    chk("reset res_timeout", resTimeout, 0);
    #2;
    reset = 1'b1;
    tick;
    chk("op_ready after release", opReady, 1);

    runJob(8'h0C, 8'h08, 5, 0, "basic");
    runJob(8'h0C, 8'h08, 5, 10, "backpressure");
    runJob(8'h1E, 8'h14, TO - 2, 1, "edge_no_timeout");
    runJob(8'h1E, 8'h14, TO - 1, 1, "edge_timeout");

    mode = 1;
    runJob(8'h0C, 8'h08, 5, 2, "never_starts");
    mode = 2;
    tick;
    runJob(8'h0C, 8'h08, 5, 2, "stuck_busy");
    mode = 0;
    tick;
    waitIdle();

    // Abort from WAIT_DONE: outputs must clear in the same cycle.
    runJob(8'h2A, 8'h1C, 5, 0, "pre_reset");
    curB = 6;
    opValid = 1'b1;
    opA = 8'h30;
    opB = 8'h12;
    tick;
    opValid = 1'b0;
    tick;
    tick;
    tick;
    #2;
    reset = 1'b0;
    #1;
    chk("midjob res_valid", resValid, 0);
    chk("midjob res_data", resData, 0);
    chk("midjob InA", procInA, 0);
    chk("midjob InB", procInB, 0);
    chk("midjob start", procStart, 0);
    tick;
    tick;
    #2;
    reset = 1'b1;
    tick;
    chk("midjob op_ready", opReady, 1);
    runJob(8'h15, 8'h0E, 5, 0, "after_reset");

    for (int i = 0; i < 30; i++) begin
      runJob(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             $urandom_range(1, 18), $urandom_range(0, 3), "rand");
    end

    doReset();
    ba[0] = 8'h30; bb[0] = 8'h24;
    ba[1] = 8'h11; bb[1] = 8'h07;
    ba[2] = 8'hFF; bb[2] = 8'h55;
    curB = 5;
    idx = 0;
    opValid = 1'b1;
    opA = ba[0];
    opB = bb[0];
    resReady = 1'b1;
    k = 0;
    while (got.size() < 3 && k < 200) begin
      acc = opValid && opReady;
      tk = resValid && resReady;
      d = resData;
      tick;
      k++;
      if (tk) got.push_back(d);
      if (acc) begin
        idx++;
        if (idx < 3) begin
          opA = ba[idx];
          opB = bb[idx];
        end else begin
          opValid = 1'b0;
        end
      end
    end
    resReady = 1'b0;
    chk("b2b count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b result %0d", i), (i < got.size()) ? got[i] : 8'hXX, gcd(ba[i], bb[i]));
    end
`ifdef SSPP_DRV_PERF_CNT_EN
    chk("jobs_done", jobsDone, 3);
    chk("jobs_timeout", jobsTimeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
